// File: rtl/fifo_pack_pkg.sv
// Shared types for the FIFO word packer.
package fifo_pack_pkg;

  // FILL collects words into lanes; HOLD presents the packed beat.
  typedef enum logic {FILL, HOLD} fifo_pack_state_e;

endpackage : fifo_pack_pkg

// File: rtl/fifo_pack_reader.sv
// Read-side consumer for a show-ahead FIFO: pops WIDTH-bit words and packs PACK of them
// (first-popped word in lane 0) into one valid/ready output beat.
// Optional feature macro: FIFO_PACK_FLUSH_EN enables flush_i to emit partial beats with a
// per-lane out_keep_o mask; without it flush_i is ignored and out_keep_o is all ones.
module fifo_pack_reader
  import fifo_pack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      fifo_data_i,
  input  logic                  fifo_valid_i,
  output logic                  fifo_ren_o,
  output logic [PACK*WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PACK-1:0]       out_keep_o,
  input  logic                  flush_i
);

  localparam int unsigned CntW = (PACK > 1) ? $clog2(PACK) : 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastLane = cnt_t'(PACK - 1);

  fifo_pack_state_e            state_q, state_d;
  cnt_t                        fill_cnt_q, fill_cnt_d;
  logic [PACK-1:0][WIDTH-1:0]  lanes_q, lanes_d;
  logic                        pop;
  cnt_t                        wr_lane;

`ifdef FIFO_PACK_FLUSH_EN
  logic [PACK-1:0]             keep_q, keep_d;
  logic [CntW:0]               fill_n;
  logic [PACK-1:0]             keep_mask;
`endif

  // Pop whenever a lane is free: while filling, or while the held beat is being accepted.
  always_comb begin
    pop = fifo_valid_i & ((state_q == FILL) | ((state_q == HOLD) & out_ready_i));
  end

  assign fifo_ren_o  = pop;
  assign out_valid_o = (state_q == HOLD);
  assign out_data_o  = lanes_q;

  // Indexed lane write; a pop during a HOLD hand-off starts the next beat in lane 0.
  always_comb begin
    lanes_d = lanes_q;
    wr_lane = (state_q == HOLD) ? '0 : fill_cnt_q;
    if (pop) begin
      lanes_d[wr_lane] = fifo_data_i;
    end
  end

`ifdef FIFO_PACK_FLUSH_EN
  // Effective lane count for a flush, counting a word popped in the same cycle.
  always_comb begin
    fill_n = {1'b0, fill_cnt_q} + {{CntW{1'b0}}, pop};
    for (int unsigned i = 0; i < PACK; i++) begin
      keep_mask[i] = (fill_n > (CntW + 1)'(i));
    end
  end
`endif

  // Next-state logic for the FILL/HOLD machine and the lane counter.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
`ifdef FIFO_PACK_FLUSH_EN
    keep_d     = keep_q;
`endif
    unique case (state_q)
      FILL: begin
        if (pop) begin
          if (fill_cnt_q == LastLane) begin
            state_d    = HOLD;
            fill_cnt_d = '0;
`ifdef FIFO_PACK_FLUSH_EN
            keep_d     = '1;
`endif
          end else begin
            fill_cnt_d = fill_cnt_q + cnt_t'(1);
          end
        end
`ifdef FIFO_PACK_FLUSH_EN
        // A flush with nothing collected is ignored; otherwise emit what we have.
        if (flush_i && (fill_n != '0)) begin
          state_d    = HOLD;
          fill_cnt_d = '0;
          keep_d     = keep_mask;
        end
`endif
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d    = FILL;
          fill_cnt_d = pop ? cnt_t'(1) : '0;
        end
      end
      default: begin
        state_d    = FILL;
        fill_cnt_d = '0;
      end
    endcase
  end

  // State, counter and beat registers; reset discards any partial beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      lanes_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      lanes_q    <= lanes_d;
    end
  end

`ifdef FIFO_PACK_FLUSH_EN
  // Lane-valid mask register; only flushed beats clear upper bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_q <= '1;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign out_keep_o = keep_q;
`else
  // Only full beats exist, so every lane is always valid.
  logic unused_flush;
  assign unused_flush = flush_i;
  assign out_keep_o   = '1;
`endif

endmodule : fifo_pack_reader

// File: tb/tb_fifo_pack_reader.sv
// Directed bench for fifo_pack_reader with a queue-based FIFO model and a beat scoreboard.
module tb_fifo_pack_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PACK  = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  fifo_data;
  logic        fifo_valid;
  logic        fifo_ren;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_keep;
  logic        flush;

  logic [7:0]  fq[$];
  beat_t       sb[$];
  logic        gate;
  int          checks;
  int          errors;

  fifo_pack_reader #(
    .WIDTH (WIDTH),
    .PACK  (PACK)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_data_i  (fifo_data),
    .fifo_valid_i (fifo_valid),
    .fifo_ren_o   (fifo_ren),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_keep_o   (out_keep),
    .flush_i      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
  endtask

  // One clock: drive FIFO head, sample before the edge, pop the model after it.
  task automatic cycle(output logic ren);
    beat_t       exp_b;
    logic [31:0] m;
    logic [7:0]  dummy;
    fifo_valid = gate && (fq.size() > 0);
    fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
    #1;
    ren = fifo_ren;
    if (!fifo_valid) chk("ren_when_empty", {63'd0, ren}, 64'd0);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        for (int l = 0; l < 4; l++) m[l*8 +: 8] = {8{exp_b.keep[l]}};
        chk("beat_data", {32'd0, out_data & m}, {32'd0, exp_b.data & m});
        chk("beat_keep", {60'd0, out_keep}, {60'd0, exp_b.keep});
      end
    end
    @(posedge clk);
    if (ren && fq.size() > 0) dummy = fq.pop_front();
    @(negedge clk);
  endtask

  initial begin
    logic r;
    int   n;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    fifo_data  = 8'h00;
    fifo_valid = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    gate       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_keep", {60'd0, out_keep}, 64'hF);
    chk("rst_ren", {63'd0, fifo_ren}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic full beat with downstream always ready.
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    sb.push_back('{data: 32'h44332211, keep: 4'hF});
    for (int i = 0; i < 4; i++) begin
      cycle(r);
      chk("t1_ren", {63'd0, r}, 64'd1);
    end
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_data", {32'd0, out_data}, 64'h44332211);
    chk("t1_keep", {60'd0, out_keep}, 64'hF);
    cycle(r);
    chk("t1_idle_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: hold the beat, then pop on the same cycle the beat is accepted.
    out_ready = 1'b0;
    for (int w = 1; w <= 8; w++) push(8'(w * 8'h11));
    sb.push_back('{data: 32'h44332211, keep: 4'hF});
    sb.push_back('{data: 32'h88776655, keep: 4'hF});
    for (int i = 0; i < 4; i++) begin
      cycle(r);
      chk("t2_fill_ren", {63'd0, r}, 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(r);
      chk("t2_hold_ren", {63'd0, r}, 64'd0);
      chk("t2_hold_data", {32'd0, out_data}, 64'h44332211);
      chk("t2_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    cycle(r);
    chk("t2_handoff_ren", {63'd0, r}, 64'd1);
    chk("t2_handoff_valid", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(r);
      chk("t2_refill_ren", {63'd0, r}, 64'd1);
    end
    chk("t2_beat2_data", {32'd0, out_data}, 64'h88776655);
    cycle(r);

    // Intermittent FIFO valid: pops only when valid is presented.
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    sb.push_back('{data: 32'hA4A3A2A1, keep: 4'hF});
    for (int i = 0; i < 8; i++) begin
      gate = (i % 2 == 0);
      cycle(r);
      chk("t3_ren", {63'd0, r}, {63'd0, gate});
    end
    gate = 1'b1;
    chk("t3_drained", {63'd0, sb.size() == 0}, 64'd1);

    // Flush after two words.
    push(8'hAA); push(8'hBB);
    cycle(r);
    cycle(r);
    flush = 1'b1;
    cycle(r);
    flush = 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
    chk("t4_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_keep", {60'd0, out_keep}, 64'h3);
    chk("t4_data_lo", {48'd0, out_data[15:0]}, 64'hBBAA);
    sb.push_back('{data: 32'h0000BBAA, keep: 4'h3});
    cycle(r);
    // Nothing collected: flush must be ignored.
    flush = 1'b1;
    cycle(r);
    flush = 1'b0;
    chk("t4_empty_flush", {63'd0, out_valid}, 64'd0);
`else
    chk("t4_no_beat", {63'd0, out_valid}, 64'd0);
    push(8'hCC); push(8'hDD);
    sb.push_back('{data: 32'hDDCCBBAA, keep: 4'hF});
    cycle(r);
    cycle(r);
    chk("t4_resume_valid", {63'd0, out_valid}, 64'd1);
    cycle(r);
`endif

    // Flush coincident with the final pop yields a normal full beat.
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    sb.push_back('{data: 32'hC4C3C2C1, keep: 4'hF});
    for (int i = 0; i < 3; i++) cycle(r);
    flush = 1'b1;
    cycle(r);
    flush = 1'b0;
    chk("t5_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_keep", {60'd0, out_keep}, 64'hF);
    cycle(r);

    // Reset mid-fill discards the partial beat.
    push(8'hE1); push(8'hE2); push(8'hE3);
    for (int i = 0; i < 3; i++) cycle(r);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_data", {32'd0, out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    sb.push_back('{data: 32'h04030201, keep: 4'hF});
    for (int i = 0; i < 4; i++) cycle(r);
    chk("t6_fresh_data", {32'd0, out_data}, 64'h04030201);

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      cycle(r);
      n++;
    end
    chk("sb_drained", {63'd0, sb.size() == 0}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_pack_reader
